// File: rtl/mem_access_unit_if.sv
// Datapath + SRAM signal bundle for mem_access_unit.
// The slave modport is the unit's own view; master is the surrounding datapath/SRAM.
interface mem_access_unit_if #(
   parameter int ADDR_W = 32
);
   logic              req;
   logic              we;
   logic [1:0]        size;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              busy;
   logic              done;
   logic              err;
   logic [31:0]       rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-3:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_be;
   logic [31:0]       mem_rdata;

   modport slave (
      input  req, we, size, addr, wdata, mem_rdata,
      output busy, done, err, rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be
   );

   modport master (
      output req, we, size, addr, wdata, mem_rdata,
      input  busy, done, err, rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store engine: runs each decoder memory request as a short SRAM transaction.
// Define MEM_BYTE_ENABLE_EN when the SRAM honours byte enables; otherwise sub-word stores do read-modify-write.
module mem_access_unit #(
   parameter int ADDR_W = 32
) (
   input logic              clk,
   input logic              rst_n,
   mem_access_unit_if.slave bus
);

`ifdef MEM_BYTE_ENABLE_EN
   localparam bit BE_EN = 1'b1;
`else
   localparam bit BE_EN = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_RD, S_RDW, S_WR, S_DONE} state_t;

   localparam logic [1:0] SZ_W = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_B = 2'b10;

   state_t            r_state, w_next;
   logic              r_we;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_be;
   logic              r_err;
   logic [31:0]       r_rdata;

   logic              w_bad;
   logic [31:0]       w_st_data;
   logic [3:0]        w_st_be;
   logic [31:0]       w_merged;
   logic [31:0]       w_load;

   assign w_bad = (bus.size == 2'b11)
               || (bus.size == SZ_W && bus.addr[1:0] != 2'b00)
               || (bus.size == SZ_H && bus.addr[0]);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_st_data = bus.wdata;
      w_st_be   = 4'hF;
      if (BE_EN) begin
         case (bus.size)
            SZ_H: begin
               w_st_data = {2{bus.wdata[15:0]}};
               w_st_be   = bus.addr[1] ? 4'b1100 : 4'b0011;
            end
            SZ_B: begin
               w_st_data = {4{bus.wdata[7:0]}};
               w_st_be   = 4'b0001 << bus.addr[1:0];
            end
            default: ;
         endcase
      end
   end

   // Lane extract for loads and lane merge for read-modify-write stores
   always_comb begin
      w_merged = bus.mem_rdata;
      w_load   = bus.mem_rdata;
      case (r_size)
         SZ_H: begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            w_load = {16'h0000, bus.mem_rdata[{r_addr[1], 4'b0000} +: 16]};
         end
         SZ_B: begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            w_load = {24'h000000, bus.mem_rdata[{r_addr[1:0], 3'b000} +: 8]};
         end
         default: ;
      endcase
   end

   always_comb begin
      w_next        = r_state;
      bus.busy      = (r_state != S_IDLE);
      bus.done      = 1'b0;
      bus.err       = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = '0;
      bus.mem_be    = '0;
      case (r_state)
         S_IDLE: begin
            if (bus.req) begin
               if (w_bad)                                       w_next = S_DONE;
               else if (bus.we && (bus.size == SZ_W || BE_EN)) w_next = S_WR;
               else                                             w_next = S_RD;
            end
         end
         S_RD: begin
            bus.mem_en = 1'b1;
            bus.mem_be = 4'hF;
            w_next     = S_RDW;
         end
         S_RDW:   w_next = r_we ? S_WR : S_DONE;
         S_WR: begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_wdata = r_wdata;
            bus.mem_be    = r_be;
            w_next        = S_DONE;
         end
         S_DONE: begin
            bus.done = 1'b1;
            bus.err  = r_err;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign bus.rdata    = r_rdata;
   assign bus.mem_addr = r_addr[ADDR_W-1:2];

   // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Request capture at acceptance; RDW either loads rdata or folds the sub-word into the write word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_size  <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else if (r_state == S_IDLE && bus.req) begin
         r_we    <= bus.we;
         r_size  <= bus.size;
         r_addr  <= bus.addr;
         r_wdata <= w_st_data;
         r_be    <= w_st_be;
         r_err   <= w_bad;
      end else if (r_state == S_RDW) begin
         if (r_we) r_wdata <= w_merged;
         else      r_rdata <= w_load;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written corner sequences,
// and random traffic against a word-array reference model. Honours MEM_BYTE_ENABLE_EN like the RTL.
module tb_mem_access_unit;
   localparam int ADDR_W = 32;
`ifdef MEM_BYTE_ENABLE_EN
   localparam bit BE_BUILD = 1'b1;
`else
   localparam bit BE_BUILD = 1'b0;
`endif
   localparam int SUB_LAT = BE_BUILD ? 2 : 4;
   localparam int SUB_NRD = BE_BUILD ? 0 : 1;

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        err;
      int          lat;
      logic [31:0] rdata;
      logic [31:0] word;
      int          nwr;
      int          nrd;
      logic [31:0] mwd;
      logic [3:0]  mbe;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();
   mem_access_unit #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // Synchronous SRAM model with a back-door preload port
   logic [31:0] sram [0:255];
   logic        pl_en = 1'b0;
   logic [7:0]  pl_idx;
   logic [31:0] pl_data;

   always @(posedge clk) begin
      logic [31:0] t;
      if (pl_en) sram[pl_idx] <= pl_data;
      else if (bus.mem_en) begin
         if (bus.mem_we) begin
            t = sram[bus.mem_addr[7:0]];
            for (int k = 0; k < 4; k++)
               if (bus.mem_be[k]) t[8*k +: 8] = bus.mem_wdata[8*k +: 8];
            sram[bus.mem_addr[7:0]] <= t;
         end else begin
            bus.mem_rdata <= sram[bus.mem_addr[7:0]];
         end
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   // Observed results of the most recent transaction
   int          a_lat, a_nwr, a_nrd;
   logic        a_err;
   logic [31:0] a_rd, a_mwd;
   logic [3:0]  a_mbe;

   task automatic run_txn(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      bus.req = 1'b1; bus.we = we; bus.size = sz; bus.addr = a; bus.wdata = wd;
      @(posedge clk);
      #1 bus.req = 1'b0;
      a_lat = 0; a_nwr = 0; a_nrd = 0; a_err = 1'b0; a_rd = '0; a_mwd = '0; a_mbe = '0;
      while (a_lat < 20) begin
         @(negedge clk);
         a_lat++;
         if (bus.mem_en) begin
            if (bus.mem_we) begin
               a_nwr++; a_mwd = bus.mem_wdata; a_mbe = bus.mem_be;
            end else a_nrd++;
         end
         if (bus.done) begin
            a_err = bus.err; a_rd = bus.rdata;
            break;
         end
      end
   endtask

   task automatic check_txn(input string tag, input vec_t v);
      check({tag, " latency"}, a_lat, v.lat);
      check({tag, " err"}, a_err, v.err);
      check({tag, " rdata"}, a_rd, v.rdata);
      check({tag, " sram word"}, sram[v.addr[9:2]], v.word);
      check({tag, " writes"}, a_nwr, v.nwr);
      check({tag, " reads"}, a_nrd, v.nrd);
      check({tag, " mem_wdata"}, a_mwd, v.mwd);
      check({tag, " mem_be"}, a_mbe, v.mbe);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " busy"}, bus.busy, 0);
      check({tag, " done"}, bus.done, 0);
      check({tag, " err"}, bus.err, 0);
      check({tag, " mem_en"}, bus.mem_en, 0);
      check({tag, " mem_we"}, bus.mem_we, 0);
      check({tag, " rdata"}, bus.rdata, 0);
      check({tag, " mem_wdata"}, bus.mem_wdata, 0);
      check({tag, " mem_addr"}, bus.mem_addr, 0);
      check({tag, " mem_be"}, bus.mem_be, 0);
   endtask

   // Reference model: SRAM as a word array, lanes handled with masks and shifts
   logic [31:0] ref_mem [0:255];
   logic [31:0] ref_rdata;

   function automatic vec_t model(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      vec_t        v;
      int          idx, sh;
      logic [31:0] mask, old, nw;
      idx  = int'(a >> 2);
      old  = ref_mem[idx];
      sh   = (sz == 2'd1) ? 16 * int'(a[1]) : (sz == 2'd2) ? 8 * int'(a[1:0]) : 0;
      mask = (sz == 2'd0) ? 32'hFFFF_FFFF : (sz == 2'd1) ? (32'h0000_FFFF << sh) : (32'h0000_00FF << sh);
      v.we = we; v.sz = sz; v.addr = a; v.wd = wd;
      v.err = 1'b0; v.nwr = 0; v.nrd = 0; v.mwd = '0; v.mbe = '0;
      if (sz == 2'd3 || (sz == 2'd0 && a[1:0] != 2'd0) || (sz == 2'd1 && a[0])) begin
         v.err = 1'b1; v.lat = 1;
      end else if (!we) begin
         v.lat = 3; v.nrd = 1;
         ref_rdata = (old & mask) >> sh;
      end else begin
         nw = (old & ~mask) | ((wd << sh) & mask);
         ref_mem[idx] = nw;
         v.nwr = 1;
         if (sz == 2'd0) begin
            v.lat = 2; v.mwd = wd; v.mbe = 4'hF;
         end else if (BE_BUILD) begin
            v.lat = 2;
            v.mwd = (sz == 2'd1) ? {16'h0000, wd[15:0]} * 32'h0001_0001 : {24'h000000, wd[7:0]} * 32'h0101_0101;
            v.mbe = {mask[24], mask[16], mask[8], mask[0]};
         end else begin
            v.lat = 4; v.nrd = 1; v.mwd = nw; v.mbe = 4'hF;
         end
      end
      v.rdata = ref_rdata;
      v.word  = ref_mem[idx];
      return v;
   endfunction

   vec_t        tbl [12];
   vec_t        ev;
   int          cnt;
   logic        seen;
   logic        rw;
   logic [1:0]  rsz;
   logic [31:0] ra, rwd, pv;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish by %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      //          we    sz     addr    wdata          err  lat      rdata          sram word     nwr nrd      mem_wdata                                    mem_be
      tbl[0]  = '{1'b1, 2'd0, 32'h10, 32'hDEADBEEF, 1'b0, 2,       32'h0,        32'hDEADBEEF, 1, 0,       32'hDEADBEEF,                                4'hF};
      tbl[1]  = '{1'b0, 2'd0, 32'h10, 32'h0,        1'b0, 3,       32'hDEADBEEF, 32'hDEADBEEF, 0, 1,       32'h0,                                       4'h0};
      tbl[2]  = '{1'b1, 2'd0, 32'h10, 32'h11223344, 1'b0, 2,       32'hDEADBEEF, 32'h11223344, 1, 0,       32'h11223344,                                4'hF};
      tbl[3]  = '{1'b1, 2'd2, 32'h12, 32'h123456AB, 1'b0, SUB_LAT, 32'hDEADBEEF, 32'h11AB3344, 1, SUB_NRD, BE_BUILD ? 32'hABABABAB : 32'h11AB3344, BE_BUILD ? 4'b0100 : 4'hF};
      tbl[4]  = '{1'b0, 2'd2, 32'h23, 32'h0,        1'b0, 3,       32'h88,       32'h8899AABB, 0, 1,       32'h0,                                       4'h0};
      tbl[5]  = '{1'b0, 2'd1, 32'h22, 32'h0,        1'b0, 3,       32'h8899,     32'h8899AABB, 0, 1,       32'h0,                                       4'h0};
      tbl[6]  = '{1'b0, 2'd1, 32'h20, 32'h0,        1'b0, 3,       32'hAABB,     32'h8899AABB, 0, 1,       32'h0,                                       4'h0};
      tbl[7]  = '{1'b0, 2'd0, 32'h21, 32'h0,        1'b1, 1,       32'hAABB,     32'h8899AABB, 0, 0,       32'h0,                                       4'h0};
      tbl[8]  = '{1'b1, 2'd1, 32'h13, 32'h5555,     1'b1, 1,       32'hAABB,     32'h11AB3344, 0, 0,       32'h0,                                       4'h0};
      tbl[9]  = '{1'b0, 2'd3, 32'h10, 32'h0,        1'b1, 1,       32'hAABB,     32'h11AB3344, 0, 0,       32'h0,                                       4'h0};
      tbl[10] = '{1'b1, 2'd1, 32'h12, 32'h9999CAFE, 1'b0, SUB_LAT, 32'hAABB,     32'hCAFE3344, 1, SUB_NRD, BE_BUILD ? 32'hCAFECAFE : 32'hCAFE3344, BE_BUILD ? 4'b1100 : 4'hF};
      tbl[11] = '{1'b0, 2'd2, 32'h11, 32'h0,        1'b0, 3,       32'h33,       32'hCAFE3344, 0, 1,       32'h0,                                       4'h0};

      bus.req = 1'b0; bus.we = 1'b0; bus.size = '0; bus.addr = '0; bus.wdata = '0;
      #1 rst_n = 1'b0;
      #2 check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 64; i++) begin
         pv = (i == 8) ? 32'h8899AABB : $urandom;
         ref_mem[i] = pv;
         @(negedge clk);
         pl_en = 1'b1; pl_idx = 8'(i); pl_data = pv;
      end
      @(negedge clk) pl_en = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run_txn(tbl[i].we, tbl[i].sz, tbl[i].addr, tbl[i].wd);
         check_txn($sformatf("vec%0d", i), tbl[i]);
      end

      // Back-to-back: req held through DONE; inputs changed while busy must not affect the first load
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd0; bus.addr = 32'h10;
      @(posedge clk);
      #1 bus.addr = 32'h20;
      cnt = 0;
      while (!bus.done && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check("b2b first latency", cnt, 3);
      check("b2b first rdata", bus.rdata, 32'hCAFE3344);
      @(negedge clk);
      check("b2b idle busy", bus.busy, 0);
      cnt = 1;
      while (!bus.done && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      bus.req = 1'b0;
      check("b2b second latency", cnt, 4);
      check("b2b second rdata", bus.rdata, 32'h8899AABB);

      // Misaligned load, then a req pulse during its DONE cycle must be dropped
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd0; bus.addr = 32'h21;
      @(posedge clk);
      #1 bus.req = 1'b0;
      @(negedge clk);
      check("misaligned done", bus.done, 1);
      check("misaligned err", bus.err, 1);
      check("misaligned mem_en", bus.mem_en, 0);
      check("misaligned rdata", bus.rdata, 32'h8899AABB);
      bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd0; bus.addr = 32'h10; bus.wdata = 32'h0;
      @(posedge clk);
      #1 bus.req = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.busy || bus.mem_en) seen = 1'b1;
      end
      check("pulse in DONE ignored", seen, 0);
      check("pulse in DONE sram", sram[4], 32'hCAFE3344);

      // Req pulse during a load's RD cycle must be dropped
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd1; bus.addr = 32'h22;
      @(posedge clk);
      #1 bus.req = 1'b0;
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd0; bus.addr = 32'h20; bus.wdata = 32'h0;
      @(posedge clk);
      #1 bus.req = 1'b0;
      cnt = 1;
      while (!bus.done && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check("busy pulse latency", cnt, 3);
      check("busy pulse rdata", bus.rdata, 32'h8899);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.busy || bus.mem_en) seen = 1'b1;
      end
      check("pulse in RD ignored", seen, 0);
      check("pulse in RD sram", sram[8], 32'h8899AABB);

      // Random traffic against the reference model (words 16..63 are untouched by directed tests)
      for (int i = 0; i < 60; i++) begin
         if (i == 0) begin
            rw = 1'b0; rsz = 2'd0; ra = 32'h40; rwd = 32'h0;
         end else begin
            rw  = 1'($urandom_range(0, 1));
            rsz = 2'($urandom_range(0, 3));
            ra  = 32'($urandom_range(64, 255));
            rwd = $urandom;
            if ($urandom_range(0, 3) != 0)
               ra = ra & ((rsz == 2'd0) ? ~32'h3 : (rsz == 2'd1) ? ~32'h1 : ~32'h0);
         end
         ev = model(rw, rsz, ra, rwd);
         run_txn(rw, rsz, ra, rwd);
         check_txn($sformatf("rnd%0d", i), ev);
      end

      // Reset during RDW: byte store in the RMW build, word load otherwise
      @(negedge clk);
      bus.req = 1'b1; bus.we = !BE_BUILD; bus.size = BE_BUILD ? 2'd0 : 2'd2;
      bus.addr = BE_BUILD ? 32'h10 : 32'h12; bus.wdata = 32'h55;
      @(posedge clk);
      #1 bus.req = 1'b0;
      @(negedge clk);
      check("pre-reset RD mem_en", bus.mem_en, 1);
      @(negedge clk);
      check("pre-reset RDW busy", bus.busy, 1);
      rst_n = 1'b0;
      #1 check_reset_outputs("mid reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      check("mid reset sram", sram[4], 32'hCAFE3344);
      run_txn(1'b0, 2'd0, 32'h10, 32'h0);
      check_txn("post reset lw", '{1'b0, 2'd0, 32'h10, 32'h0, 1'b0, 3, 32'hCAFE3344, 32'hCAFE3344, 0, 1, 32'h0, 4'h0});

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store engine between the datapath and a word-wide synchronous data SRAM. Consumes the memory controls the instruction decoder produces (write enable, access size, address, store data) and executes each access as a small multi-cycle transaction. Stores are word, half-word or byte; loads are zero-extended (lw/lhu/lbu). It holds the pipeline via `busy` until `done`.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width; SRAM word address is `ADDR_W-2` bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 1: access request; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 = word, 01 = half-word, 10 = byte, 11 = illegal.
- `addr` in ADDR_W: byte address.
- `wdata` in 32: store data; sub-word data sits in the low bits.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: pulses with `done` when the access was misaligned or illegal.
- `rdata` out 32: zero-extended load result, held until the next successful load.
- `mem_en` out 1: SRAM access strobe.
- `mem_we` out 1: SRAM write; valid only with `mem_en`.
- `mem_addr` out ADDR_W-2: word address, `addr[ADDR_W-1:2]`.
- `mem_wdata` out 32: SRAM write data.
- `mem_be` out 4: SRAM byte enables.
- `mem_rdata` in 32: SRAM read data, valid the cycle after a read strobe.

## Operation
- Little-endian lanes:
  - byte k = bits 8k+7:8k, k = `addr[1:0]`.
  - half h = bits 16h+15:16h, h = `addr[1]`.
- On `req` in IDLE, `we`/`size`/`addr`/`wdata` are registered. Inputs are ignored while `busy`.
- Alignment check at acceptance. These go directly to DONE with `err`=1, no SRAM access, and `rdata` unchanged:
  - word with `addr[1:0]`≠0
  - half with `addr[0]`=1
  - `size`=11
- FSM states: IDLE, RD, RDW, WR, DONE.
  - Load: IDLE→RD→RDW→DONE.
    - RD drives `mem_en`=1, `mem_we`=0.
    - RDW captures `mem_rdata`, extracts the lane and zero-extends into `rdata`.
  - Word store: IDLE→WR→DONE.
    - WR drives `mem_en`=1, `mem_we`=1, `mem_wdata`=`wdata`, `mem_be`=1111.
  - Sub-word store: path and write data depend on the build (see Configuration).
  - Every DONE returns to IDLE the next cycle.
- `mem_en`, `mem_we`, `mem_wdata` and `mem_be` are zero in IDLE, RDW and DONE.

## Timing
- Reset values:
  - state IDLE
  - `busy`, `done`, `err`, `mem_en`, `mem_we` = 0
  - `rdata`, `mem_wdata`, `mem_addr`, `mem_be` = 0
- Latency, counted from the `req` sampling edge to the `done` cycle:
  - misaligned: 1
  - word store: 2
  - load: 3
  - sub-word store, RMW build: 4
- `rdata` updates on the edge leaving RDW and is valid during `done`.
- Back-to-back: the earliest next acceptance is the edge after the DONE cycle. A `req` held high through DONE is taken on that edge.
- `busy` is high from the cycle after acceptance through the DONE cycle inclusive.
- `rst_n` low mid-transaction:
  - immediate return to IDLE; all outputs drop asynchronously to reset values.
  - an in-flight SRAM strobe is abandoned.
  - a half-finished RMW leaves the SRAM word unchanged, since WR is never reached.

## Configuration
- `MEM_BYTE_ENABLE_EN` defined (SRAM honours `mem_be`):
  - Sub-word stores take IDLE→WR→DONE; latency 2.
  - `mem_wdata` carries the sub-word replicated on all lanes: byte ×4, half ×2.
  - `mem_be` selects the lanes:
    - byte: one-hot `1<<addr[1:0]`
    - half: 0011 if `addr[1]`=0, 1100 if `addr[1]`=1
- Not defined (read-modify-write):
  - Sub-word stores take IDLE→RD→RDW→WR→DONE.
  - RDW merges the sub-word into the captured word.
  - WR writes the merged word with `mem_be`=1111.
  - `mem_be` is always 1111 whenever `mem_en`=1.

## Test plan
- Word round-trip: store 0xDEADBEEF @0x10, then lw @0x10.
  - SRAM word 4 = 0xDEADBEEF.
  - `rdata`=0xDEADBEEF.
  - done 2 cycles after store acceptance and 3 cycles after load acceptance.
- Byte store, RMW build: word 4 preloaded 0x11223344; sb 0xAB @0x12.
  - Word 4 = 0x11AB3344.
  - Latency 4; `rdata` unchanged.
- Byte store, `MEM_BYTE_ENABLE_EN` build: same stimulus.
  - Single write with `mem_wdata`=0xABABABAB and `mem_be`=0100.
  - Latency 2.
- Loads on word 0x8899AABB @0x20:
  - lbu @0x23 → 0x00000088.
  - lhu @0x22 → 0x00008899.
  - lhu @0x20 → 0x0000AABB.
- Misaligned: lw @0x21 and sh @0x13.
  - `done`=`err`=1 one cycle after acceptance.
  - `mem_en` never asserted; `rdata` unchanged.
  - A `req` pulse during `busy` is ignored.
- Reset mid-RMW: assert `rst_n`=0 during RDW of a byte store.
  - Outputs go to zero immediately; the SRAM word is unchanged.
  - After release, a new lw is accepted normally.
